inv_cipher: RTL and testbench



---
 rtl/inv_cipher.sv | 186 ++++++++++++++++++
 tb/tb_inv_cipher.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_cipher.sv
// AES-128 inverse cipher round engine: one decryption round per clock on a
// 128-bit state held as four column words, round keys requested by index 10..0.

module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y = INV_SBOX[a];
endmodule

// state | meaning
// IDLE  | waiting for ciphertext; key index parked at 10
// ROUND | one inverse round per valid key; rc counts 9..0
// DONE  | plaintext presented until the consumer takes it
module inv_cipher #(
    parameter int DATA_WIDTH = 32,
    parameter int NR         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ct_0_in,
    input  logic [DATA_WIDTH-1:0] ct_1_in,
    input  logic [DATA_WIDTH-1:0] ct_2_in,
    input  logic [DATA_WIDTH-1:0] ct_3_in,
    output logic [3:0]            key_idx_out,
    input  logic                  key_valid_in,
    input  logic [DATA_WIDTH-1:0] key_0_in,
    input  logic [DATA_WIDTH-1:0] key_1_in,
    input  logic [DATA_WIDTH-1:0] key_2_in,
    input  logic [DATA_WIDTH-1:0] key_3_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] pt_0_out,
    output logic [DATA_WIDTH-1:0] pt_1_out,
    output logic [DATA_WIDTH-1:0] pt_2_out,
    output logic [DATA_WIDTH-1:0] pt_3_out,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t                  fsm;
    logic [3:0]            rc;
    logic                  armed;
    logic [DATA_WIDTH-1:0] st    [4];
    logic [DATA_WIDTH-1:0] ct_w  [4];
    logic [DATA_WIDTH-1:0] key_w [4];
    logic [DATA_WIDTH-1:0] ark   [4];
    logic [DATA_WIDTH-1:0] imc   [4];
    logic [7:0]            sr_b  [16];
    logic [7:0]            sb_b  [16];
    logic                  accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign ct_w[0]  = ct_0_in;
    assign ct_w[1]  = ct_1_in;
    assign ct_w[2]  = ct_2_in;
    assign ct_w[3]  = ct_3_in;
    assign key_w[0] = key_0_in;
    assign key_w[1] = key_1_in;
    assign key_w[2] = key_2_in;
    assign key_w[3] = key_3_in;

    // InvShiftRows: row r of column c comes from column (c - r) mod 4
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_b[c*4+r] = st[(c - r + 4) % 4][31-8*r -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .a (sr_b[g]),
            .y (sb_b[g])
        );
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            ark[c] = {sb_b[c*4], sb_b[c*4+1], sb_b[c*4+2], sb_b[c*4+3]} ^ key_w[c];
            imc[c] = inv_mix_col(ark[c]);
        end
    end

    // armed keeps in_ready low until the first clock after reset release
    assign in_ready = armed && (fsm == IDLE) && key_valid_in;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm   <= IDLE;
            rc    <= 4'(NR);
            armed <= 1'b0;
            for (int i = 0; i < 4; i++) st[i] <= '0;
        end else begin
            armed <= 1'b1;
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < 4; i++) st[i] <= ct_w[i] ^ key_w[i];
                        rc  <= 4'(NR - 1);
                        fsm <= ROUND;
                    end
                end
                ROUND: begin
                    if (key_valid_in) begin
                        if (rc == 4'd0) begin
                            for (int i = 0; i < 4; i++) st[i] <= ark[i];
                            fsm <= DONE;
                        end else begin
                            for (int i = 0; i < 4; i++) st[i] <= imc[i];
                            rc <= rc - 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        rc  <= 4'(NR);
                        fsm <= IDLE;
                    end
                end
                default: begin
                    rc  <= 4'(NR);
                    fsm <= IDLE;
                end
            endcase
        end
    end

    // rc already sits at 10 in IDLE and 0 in DONE, so it doubles as the key index
    assign key_idx_out = rc;
    assign out_valid   = (fsm == DONE);
    assign busy        = (fsm != IDLE);
    assign pt_0_out    = out_valid ? st[0] : '0;
    assign pt_1_out    = out_valid ? st[1] : '0;
    assign pt_2_out    = out_valid ? st[2] : '0;
    assign pt_3_out    = out_valid ? st[3] : '0;
endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher: FIPS-197 vectors, key stalls, backpressure,
// back-to-back blocks and mid-block reset; round keys come from a local key expansion.

module tb_inv_cipher;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] ct_0_in, ct_1_in, ct_2_in, ct_3_in;
    logic [3:0]    key_idx_out;
    logic          key_valid_in;
    logic [DW-1:0] key_0_in, key_1_in, key_2_in, key_3_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] pt_0_out, pt_1_out, pt_2_out, pt_3_out;
    logic          busy;

    logic [127:0]  ct_w;
    logic [31:0]   rk_tab [0:1][0:43];
    logic          ksel;
    logic [7:0]    sbox_t [0:255];
    logic [127:0]  pt_all;
    int            ncomp = 0;
    int            nerr  = 0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 clk = ~clk;

    assign ct_0_in  = ct_w[127:96];
    assign ct_1_in  = ct_w[95:64];
    assign ct_2_in  = ct_w[63:32];
    assign ct_3_in  = ct_w[31:0];
    assign key_0_in = rk_tab[ksel][{key_idx_out, 2'd0}];
    assign key_1_in = rk_tab[ksel][{key_idx_out, 2'd1}];
    assign key_2_in = rk_tab[ksel][{key_idx_out, 2'd2}];
    assign key_3_in = rk_tab[ksel][{key_idx_out, 2'd3}];
    assign pt_all   = {pt_0_out, pt_1_out, pt_2_out, pt_3_out};

    inv_cipher #(.DATA_WIDTH(DW), .NR(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ct_0_in      (ct_0_in),
        .ct_1_in      (ct_1_in),
        .ct_2_in      (ct_2_in),
        .ct_3_in      (ct_3_in),
        .key_idx_out  (key_idx_out),
        .key_valid_in (key_valid_in),
        .key_0_in     (key_0_in),
        .key_1_in     (key_1_in),
        .key_2_in     (key_2_in),
        .key_3_in     (key_3_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pt_0_out     (pt_0_out),
        .pt_1_out     (pt_1_out),
        .pt_2_out     (pt_2_out),
        .pt_3_out     (pt_3_out),
        .busy         (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // forward S-box from its definition: GF(2^8) inverse followed by the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] key, input int slot);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) rk_tab[slot][i] = w[i];
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] ct, input bit keep, input string tag);
        int n = 0;
        ct_w     = ct;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_accept"}, 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    // follows one block from just after acceptance until out_valid, with optional key stalls
    task automatic track(input logic [127:0] exp_pt, input int exp_lat,
                         input int st5, input int st0, input string tag);
        int k   = 9;
        int cnt = 0;
        int n5  = st5;
        int n0  = st0;
        bit done = 1'b0;
        while (!done && cnt < 100) begin
            if (k == 5 && n5 > 0) begin
                key_valid_in = 1'b0;
                n5--;
            end else if (k == 0 && n0 > 0) begin
                key_valid_in = 1'b0;
                n0--;
            end else begin
                key_valid_in = 1'b1;
            end
            check({tag, "_kidx"}, 128'(key_idx_out), 128'(k));
            check({tag, "_inrdy_busy"}, 128'(in_ready), 128'(0));
            check({tag, "_pt_zero"}, pt_all, 128'(0));
            @(posedge clk); #1;
            cnt++;
            if (key_valid_in) begin
                if (k == 0) done = 1'b1;
                else k--;
            end
            check({tag, "_oval"}, 128'(out_valid), 128'(done));
        end
        key_valid_in = 1'b1;
        check({tag, "_latency"}, 128'(cnt), 128'(exp_lat));
        check({tag, "_pt"}, pt_all, exp_pt);
        check({tag, "_kidx_done"}, 128'(key_idx_out), 128'(0));
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_oval_clr"}, 128'(out_valid), 128'(0));
        check({tag, "_busy_clr"}, 128'(busy), 128'(0));
        check({tag, "_kidx_idle"}, 128'(key_idx_out), 128'(10));
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        key_valid_in = 1'b1;
        ksel         = 1'b0;
        ct_w         = '0;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        expand(KEY1, 0);
        expand(KEY2, 1);

        #12;
        check("rst_oval", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_pt", pt_all, 128'(0));
        check("rst_kidx", 128'(key_idx_out), 128'(10));
        check("rst_inrdy", 128'(in_ready), 128'(0));
        rst_n = 1'b1;
        #1;
        check("rel_inrdy", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        check("armed_inrdy", 128'(in_ready), 128'(1));
        key_valid_in = 1'b0;
        #1;
        check("idle_nokey_inrdy", 128'(in_ready), 128'(0));
        key_valid_in = 1'b1;

        // 1: FIPS-197 C.1
        send(CT1, 1'b0, "s1");
        track(PT1, 10, 0, 0, "s1");
        finish_out("s1");

        // 2: FIPS-197 appendix B
        ksel = 1'b1;
        send(CT2, 1'b0, "s2");
        track(PT2, 10, 0, 0, "s2");
        finish_out("s2");

        // 3: key stalls at rc=5 (3 cycles) and rc=0 (1 cycle)
        ksel = 1'b0;
        send(CT1, 1'b0, "s3");
        track(PT1, 14, 3, 1, "s3");
        finish_out("s3");

        // 4: output backpressure with ignored input pulses
        ksel      = 1'b1;
        out_ready = 1'b0;
        send(CT2, 1'b0, "s4");
        track(PT2, 10, 0, 0, "s4");
        ct_w = CT1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            check("s4_hold_oval", 128'(out_valid), 128'(1));
            check("s4_hold_pt", pt_all, PT2);
            check("s4_hold_inrdy", 128'(in_ready), 128'(0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("s4_still_oval", 128'(out_valid), 128'(1));
        check("s4_still_pt", pt_all, PT2);
        finish_out("s4");
        ksel = 1'b0;
        send(CT1, 1'b0, "s4b");
        track(PT1, 10, 0, 0, "s4b");
        finish_out("s4b");

        // 5: back-to-back with in_valid held high
        send(CT1, 1'b1, "s5a");
        ct_w = CT2;
        track(PT1, 10, 0, 0, "s5a");
        ksel = 1'b1;
        check("s5_done_inrdy", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        check("s5_gap_busy", 128'(busy), 128'(0));
        check("s5_gap_inrdy", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        check("s5_acc12_busy", 128'(busy), 128'(1));
        in_valid = 1'b0;
        track(PT2, 10, 0, 0, "s5b");
        finish_out("s5b");

        // 6: reset while rc=4
        ksel = 1'b0;
        send(CT1, 1'b0, "s6");
        n = 0;
        while (key_idx_out != 4'd4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("s6_reach_rc4", 128'(key_idx_out), 128'(4));
        rst_n = 1'b0;
        #1;
        check("s6_rst_kidx", 128'(key_idx_out), 128'(10));
        check("s6_rst_busy", 128'(busy), 128'(0));
        check("s6_rst_oval", 128'(out_valid), 128'(0));
        check("s6_rst_pt", pt_all, 128'(0));
        check("s6_rst_inrdy", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        check("s6_rst_oval2", 128'(out_valid), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(CT1, 1'b0, "s6b");
        track(PT1, 10, 0, 0, "s6b");
        finish_out("s6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
        $finish;
    end
endmodule
